// File: rtl/ray_bus_arbiter_if.sv
// ray_bus_arbiter_if
//   Bundles the RayUnit-side and memory-side bus signals of ray_bus_arbiter.
//   Upstream request channel (upMs*), upstream response channel (upSm*),
//   downstream request channel (ms*), downstream response channel (sm*),
//   and the dropCount statistic.
//   Modports:
//     master - the arbiter's view (drives upMsTaken, upSm*, ms*, smTaken, dropCount)
//     slave  - the surrounding environment's view (RayUnits + memory side)
interface ray_bus_arbiter_if #(
  parameter int NUM_UNITS       = 4,
  parameter int DATA_WIDTH      = 24,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MASTER_ID_WIDTH = 8,
  parameter int COUNT_WIDTH     = 16
);
  logic [NUM_UNITS*MASTER_ID_WIDTH-1:0] upMsID;
  logic [NUM_UNITS*ADDRESS_WIDTH-1:0]   upMsAddress;
  logic [NUM_UNITS*DATA_WIDTH-1:0]      upMsData;
  logic [NUM_UNITS-1:0]                 upMsWrite;
  logic [NUM_UNITS-1:0]                 upMsValid;
  logic [NUM_UNITS-1:0]                 upMsTaken;
  logic [DATA_WIDTH-1:0]                upSmData;
  logic [NUM_UNITS-1:0]                 upSmValid;
  logic [NUM_UNITS-1:0]                 upSmTaken;
  logic [MASTER_ID_WIDTH-1:0]           msID;
  logic [ADDRESS_WIDTH-1:0]             msAddress;
  logic [DATA_WIDTH-1:0]                msData;
  logic                                 msWrite;
  logic                                 msValid;
  logic                                 msTaken;
  logic [MASTER_ID_WIDTH-1:0]           smID;
  logic [DATA_WIDTH-1:0]                smData;
  logic                                 smValid;
  logic                                 smTaken;
  logic [COUNT_WIDTH-1:0]               dropCount;

  modport master (
    input  upMsID, upMsAddress, upMsData, upMsWrite, upMsValid,
    output upMsTaken,
    output upSmData, upSmValid,
    input  upSmTaken,
    output msID, msAddress, msData, msWrite, msValid,
    input  msTaken,
    input  smID, smData, smValid,
    output smTaken,
    output dropCount
  );

  modport slave (
    output upMsID, upMsAddress, upMsData, upMsWrite, upMsValid,
    input  upMsTaken,
    input  upSmData, upSmValid,
    output upSmTaken,
    input  msID, msAddress, msData, msWrite, msValid,
    output msTaken,
    output smID, smData, smValid,
    input  smTaken,
    input  dropCount
  );
endinterface

// File: rtl/ray_bus_arbiter.sv
// ray_bus_arbiter
//   Shares one MemoryBus slave port among NUM_UNITS RayUnit masters.
//   Requests: round-robin arbitration into a one-entry registered output stage
//   (1-cycle latency, 1 transfer/cycle while msTaken is held high).
//   Responses: purely combinational routing by smID; unit i owns ID
//   MASTER_ID_BASE+i. Responses with an unknown ID are accepted and dropped.
//   Ports:
//     clock - system clock
//     reset - asynchronous, active-low reset
//     bus   - ray_bus_arbiter_if.master (all request/response channels, dropCount)
//   Optional build macro ARB_STATS_EN: enables a saturating drop counter on
//   dropCount and per-port saturating grant counters for debug probing.
//   Without it dropCount is tied to 0.
module ray_bus_arbiter #(
  parameter int NUM_UNITS       = 4,
  parameter int DATA_WIDTH      = 24,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MASTER_ID_WIDTH = 8,
  parameter int MASTER_ID_BASE  = 5,
  parameter int COUNT_WIDTH     = 16
) (
  input logic               clock,
  input logic               reset,
  ray_bus_arbiter_if.master bus
);
  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           grant_idx;
  logic [PTR_W-1:0]           next_ptr;
  logic                       out_free;
  logic                       grant_any;
  logic [NUM_UNITS-1:0]       grant_oh;
  logic [MASTER_ID_WIDTH-1:0] sel_id;
  logic [ADDRESS_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]      sel_data;
  logic                       sel_write;
  logic [NUM_UNITS-1:0]       hit;
  logic                       routed;

  // Arbitration: scan from rr_ptr with wrap, first valid port wins.
  // Grants are suppressed while reset is asserted so that no unit sees its
  // request accepted while the output register is being cleared.
  always_comb begin
    out_free  = !bus.msValid || bus.msTaken;
    grant_any = 1'b0;
    grant_idx = '0;
    if (reset && out_free) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        if (!grant_any && bus.upMsValid[PTR_W'((int'(rr_ptr) + k) % NUM_UNITS)]) begin
          grant_any = 1'b1;
          grant_idx = PTR_W'((int'(rr_ptr) + k) % NUM_UNITS);
        end
      end
    end
    grant_oh = '0;
    if (grant_any) grant_oh[grant_idx] = 1'b1;
    next_ptr = (int'(grant_idx) == NUM_UNITS - 1) ? '0 : grant_idx + PTR_W'(1);
  end

  assign sel_id    = bus.upMsID[grant_idx*MASTER_ID_WIDTH +: MASTER_ID_WIDTH];
  assign sel_addr  = bus.upMsAddress[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign sel_data  = bus.upMsData[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_write = bus.upMsWrite[grant_idx];

  assign bus.upMsTaken = grant_oh;

  // Output register stage: loads on grant, clears when drained without a new grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.msValid   <= 1'b0;
      bus.msID      <= '0;
      bus.msAddress <= '0;
      bus.msData    <= '0;
      bus.msWrite   <= 1'b0;
      rr_ptr        <= '0;
    end else if (out_free) begin
      bus.msValid <= grant_any;
      if (grant_any) begin
        bus.msID      <= sel_id;
        bus.msAddress <= sel_addr;
        bus.msData    <= sel_data;
        bus.msWrite   <= sel_write;
        rr_ptr        <= next_ptr;
      end
    end
  end

  // Response routing: decode smID against each unit's ID in MASTER_ID_WIDTH bits.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      hit[i] = bus.smValid && (bus.smID == MASTER_ID_WIDTH'(MASTER_ID_BASE + i));
    end
    routed = |hit;
  end

  assign bus.upSmValid = hit;
  assign bus.upSmData  = bus.smData;
  // Unknown IDs are swallowed immediately so the response channel never wedges.
  assign bus.smTaken   = routed ? |(hit & bus.upSmTaken) : bus.smValid;

`ifdef ARB_STATS_EN
  logic                   unroutable;
  logic [COUNT_WIDTH-1:0] drop_cnt;
  logic [COUNT_WIDTH-1:0] grant_cnt [NUM_UNITS];

  assign unroutable = bus.smValid && !routed;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
      for (int i = 0; i < NUM_UNITS; i++) grant_cnt[i] <= '0;
    end else begin
      if (unroutable && (drop_cnt != '1)) drop_cnt <= drop_cnt + COUNT_WIDTH'(1);
      if (grant_any && (grant_cnt[grant_idx] != '1))
        grant_cnt[grant_idx] <= grant_cnt[grant_idx] + COUNT_WIDTH'(1);
    end
  end

  assign bus.dropCount = drop_cnt;
`else
  assign bus.dropCount = '0;
`endif
endmodule

// File: tb/tb_ray_bus_arbiter.sv
// tb_ray_bus_arbiter
//   Self-checking bench for ray_bus_arbiter: directed scenarios followed by
//   randomized traffic, all compared against a transaction-level reference
//   model (distance-based round-robin winner, ID-offset response routing).
module tb_ray_bus_arbiter;
  localparam int N    = 4;
  localparam int DW   = 24;
  localparam int AW   = 32;
  localparam int IW   = 8;
  localparam int BASE = 5;
  localparam int CW   = 16;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ray_bus_arbiter_if #(
    .NUM_UNITS(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .MASTER_ID_WIDTH(IW), .COUNT_WIDTH(CW)
  ) bus ();

  ray_bus_arbiter #(
    .NUM_UNITS(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .MASTER_ID_WIDTH(IW), .MASTER_ID_BASE(BASE), .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    if (BASE + N - 1 >= (1 << IW)) begin
      $display("FAIL id_range: top unit ID %0d does not fit in %0d bits", BASE + N - 1, IW);
      $fatal(1, "ID range");
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus state (sources hold payload until the model says it transferred)
  logic [N-1:0]  rq_v;
  logic [IW-1:0] rq_id   [N];
  logic [AW-1:0] rq_addr [N];
  logic [DW-1:0] rq_data [N];
  logic          rq_wr   [N];
  logic          ms_taken;
  logic [N-1:0]  us_taken;
  logic          rsp_v;
  logic [IW-1:0] rsp_id;
  logic [DW-1:0] rsp_data;

  // Reference model state
  logic          m_vld;
  logic [IW-1:0] m_id;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_wr;
  int            m_ptr;
  logic [CW-1:0] m_drop;

  // Observations from the most recent step, for directed checks
  int           last_win;
  logic [N-1:0] obs_umt;
  logic [N-1:0] obs_usv;
  logic         obs_smt;
  logic         obs_msv;
  logic [AW-1:0] obs_addr;
  logic [CW-1:0] obs_drop;
  int           grants[$];

  task automatic model_reset();
    m_vld = 1'b0; m_id = '0; m_addr = '0; m_data = '0; m_wr = 1'b0;
    m_ptr = 0; m_drop = '0;
  endtask

  task automatic clear_stim();
    rq_v = '0; ms_taken = 1'b0; us_taken = '0; rsp_v = 1'b0; rsp_id = '0; rsp_data = '0;
    for (int i = 0; i < N; i++) begin
      rq_id[i] = '0; rq_addr[i] = '0; rq_data[i] = '0; rq_wr[i] = 1'b0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.upMsValid[i]            = rq_v[i];
      bus.upMsID[i*IW +: IW]      = rq_id[i];
      bus.upMsAddress[i*AW +: AW] = rq_addr[i];
      bus.upMsData[i*DW +: DW]    = rq_data[i];
      bus.upMsWrite[i]            = rq_wr[i];
    end
    bus.upSmTaken = us_taken;
    bus.msTaken   = ms_taken;
    bus.smValid   = rsp_v;
    bus.smID      = rsp_id;
    bus.smData    = rsp_data;
  endtask

  task automatic new_req(input int u);
    rq_v[u]    = 1'b1;
    rq_id[u]   = IW'(BASE + u);
    rq_addr[u] = $urandom;
    rq_data[u] = DW'($urandom);
    rq_wr[u]   = 1'($urandom_range(0, 1));
  endtask

  // One clock cycle: drive at negedge, compare at negedge+1, advance model at posedge.
  task automatic step();
    logic         free;
    int           win;
    int           best;
    int           u;
    logic         routed;
    logic [N-1:0] one;
    logic [N-1:0] exp_umt;
    logic [N-1:0] exp_usv;
    logic         exp_smt;
    one = 1;
    @(negedge clock);
    drive();
    #1;
    free = !m_vld || ms_taken;
    win  = -1;
    best = N;
    if (free) begin
      for (int p = 0; p < N; p++) begin
        if (rq_v[p] && (((p - m_ptr + N) % N) < best)) begin
          best = (p - m_ptr + N) % N;
          win  = p;
        end
      end
    end
    exp_umt = (win >= 0) ? (one << win) : '0;
    u       = int'(rsp_id) - BASE;
    routed  = rsp_v && (u >= 0) && (u < N);
    exp_usv = routed ? (one << u) : '0;
    exp_smt = routed ? us_taken[u] : rsp_v;

    check_eq("upMsTaken", bus.upMsTaken, exp_umt);
    check_eq("msValid",   bus.msValid,   m_vld);
    check_eq("msID",      bus.msID,      m_id);
    check_eq("msAddress", bus.msAddress, m_addr);
    check_eq("msData",    bus.msData,    m_data);
    check_eq("msWrite",   bus.msWrite,   m_wr);
    check_eq("upSmValid", bus.upSmValid, exp_usv);
    check_eq("upSmData",  bus.upSmData,  rsp_data);
    check_eq("smTaken",   bus.smTaken,   exp_smt);
    check_eq("dropCount", bus.dropCount, m_drop);
    obs_umt  = bus.upMsTaken;
    obs_usv  = bus.upSmValid;
    obs_smt  = bus.smTaken;
    obs_msv  = bus.msValid;
    obs_addr = bus.msAddress;
    obs_drop = bus.dropCount;
    last_win = win;

    @(posedge clock);
    if (free) begin
      if (win >= 0) begin
        m_vld  = 1'b1;
        m_id   = rq_id[win];
        m_addr = rq_addr[win];
        m_data = rq_data[win];
        m_wr   = rq_wr[win];
        m_ptr  = (win + 1) % N;
        rq_v[win] = 1'b0;
        grants.push_back(win);
      end else begin
        m_vld = 1'b0;
      end
    end
    if (rsp_v && exp_smt) begin
      if (!routed && STATS && (m_drop != '1)) m_drop = m_drop + CW'(1);
      rsp_v = 1'b0;
    end
  endtask

  initial begin
    clear_stim();
    model_reset();
    // Reset held with arbitrary inputs
    rq_v = '1;
    for (int i = 0; i < N; i++) new_req(i);
    ms_taken = 1'b1; rsp_v = 1'b1; rsp_id = 8'h7F; rsp_data = DW'($urandom);
    drive();
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check_eq("rst_msValid",   bus.msValid,   1'b0);
    check_eq("rst_upMsTaken", bus.upMsTaken, '0);
    check_eq("rst_dropCount", bus.dropCount, '0);
    check_eq("rst_msAddress", bus.msAddress, '0);
    clear_stim();
    drive();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) step();
    check_eq("idle_msValid", obs_msv, 1'b0);

    // Single request from unit 2, downstream stalled for 3 cycles
    rq_v[2] = 1'b1; rq_id[2] = 8'd7; rq_addr[2] = 32'h100; rq_data[2] = 24'hABCDEF; rq_wr[2] = 1'b1;
    ms_taken = 1'b0;
    step();
    check_eq("single_taken", obs_umt, 4'b0100);
    step();
    check_eq("single_vld",  obs_msv, 1'b1);
    check_eq("single_addr", obs_addr, 32'h100);
    step();
    step();
    ms_taken = 1'b1;
    step();
    check_eq("single_drain_vld", obs_msv, 1'b1);
    step();
    check_eq("single_clear", obs_msv, 1'b0);

    // Routing to unit 1 (ID 6), stalled then accepted
    rsp_v = 1'b1; rsp_id = 8'd6; rsp_data = 24'h123456; us_taken = 4'b0000;
    step();
    check_eq("route_usv",   obs_usv, 4'b0010);
    check_eq("route_stall", obs_smt, 1'b0);
    us_taken = 4'b0010;
    step();
    check_eq("route_take", obs_smt, 1'b1);

    // Unknown ID dropped
    rsp_v = 1'b1; rsp_id = 8'h7F; rsp_data = 24'h0F0F0F; us_taken = '0;
    step();
    check_eq("drop_usv", obs_usv, 4'b0000);
    check_eq("drop_smt", obs_smt, 1'b1);
    step();
    check_eq("drop_count", obs_drop, STATS ? 16'd1 : 16'd0);

    // Mid-stall asynchronous reset
    new_req(0);
    ms_taken = 1'b0;
    step();
    check_eq("stall_win", last_win, 0);
    step();
    @(negedge clock); #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_msValid", bus.msValid, 1'b0);
    check_eq("async_rst_taken",   bus.upMsTaken, '0);
    clear_stim();
    model_reset();
    drive();
    @(negedge clock);
    reset = 1'b1;

    // Fairness: all units always valid, downstream always ready
    grants.delete();
    ms_taken = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) if (!rq_v[i]) new_req(i);
      step();
    end
    check_eq("fair_count", grants.size(), 6);
    for (int k = 0; k < 6 && k < grants.size(); k++) check_eq($sformatf("fair_%0d", k), grants[k], k % N);
    check_eq("fair_vld", obs_msv, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if (!rq_v[i] && ($urandom_range(0, 2) != 0)) new_req(i);
      ms_taken = ($urandom_range(0, 3) != 0);
      us_taken = N'($urandom);
      if (!rsp_v && ($urandom_range(0, 1) == 1)) begin
        rsp_v    = 1'b1;
        rsp_id   = ($urandom_range(0, 4) == 0) ? IW'($urandom) : IW'(BASE + $urandom_range(0, N - 1));
        rsp_data = DW'($urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
